// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multicycle controller.
//
// Holds the FSM state encoding, opcode and R-type funct constants, the
// ALU operation codes, the packed control bundle driven by the FSM and two
// small state-classification helpers.
//
// Optional feature: define MC_CONTROLLER_BNE_EN to add the BNEEX state (13).
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        ERROR   = 4'd12
`ifdef MC_CONTROLLER_BNE_EN
        , BNEEX = 4'd13
`endif
    } state_t;

    // Operation requested from the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    // Control bundle produced by the FSM output decoder.
    typedef struct packed {
        logic       mem_req;
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_t     aluop;
    } mc_ctrl_t;

    // States that wait for the memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    // Last state of an instruction; leaving it for FETCH retires the instruction.
    function automatic logic is_terminal(input state_t s);
        logic t;
        t = (s == MEMWB) || (s == MEMWR) || (s == RTYPEWB) || (s == BEQEX) ||
            (s == ADDIWB) || (s == JEX);
`ifdef MC_CONTROLLER_BNE_EN
        t = t || (s == BNEEX);
`endif
        return t;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec -- combinational ALU control decoder.
//
// Ports:
//   aluop      in  operation class from the FSM (add / sub / use funct)
//   funct      in  R-type function field
//   alucontrol out ALU operation, zero-extended to ALUC_W (ALUC_W >= 4)
//   funct_ok   out funct is one of the supported R-type functions; this
//                  flag depends on funct only, so DECODE can use it while
//                  aluop is still "add"
module mc_aludec
    import mc_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  aluop_t            aluop,
    input  logic [5:0]        funct,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              funct_ok
);

    logic [3:0] fn_code;
    logic [3:0] code;

    always_comb begin
        funct_ok = 1'b1;
        fn_code  = ALU_ADD;
        case (funct)
            FN_ADD:  fn_code = ALU_ADD;
            FN_SUB:  fn_code = ALU_SUB;
            FN_AND:  fn_code = ALU_AND;
            FN_OR:   fn_code = ALU_OR;
            FN_NOR:  fn_code = ALU_NOR;
            FN_XOR:  fn_code = ALU_XOR;
            FN_SLT:  fn_code = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   code = ALU_ADD;
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_FUNCT: code = fn_code;
            default:     code = ALU_ADD;
        endcase
    end

    assign alucontrol = ALUC_W'(code);

endmodule

// File: rtl/mc_controller.sv
// mc_controller -- multicycle CPU control FSM.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   op, funct          opcode and R-type function from the instruction register
//                      (stable from DECODE until the instruction retires)
//   zero               ALU zero flag, gates pcen in BEQEX/BNEEX
//   mem_ready          memory access complete
//   mem_req            memory access request
//   pcen .. regdst     datapath enables / selects
//   alusrcb, pcsrc     2-bit mux selects
//   alucontrol         ALU operation (ALUC_W bits, bits above 3 are 0)
//   error              controller halted in ERROR until reset
//   state_o            current state encoding (debug / checker visibility)
//   instret            retired-instruction counter, wraps at CNT_W bits
//
// Memory handshake: mem_req acts as "valid" and is held high for the whole
// of FETCH, MEMRD and MEMWR; mem_ready acts as "ready". The access completes,
// and the FSM advances, on the rising edge where both are high. If mem_ready
// stays low for TIMEOUT consecutive edges in one state, the FSM enters ERROR.
// A reset discards any access in flight.
//
// Optional feature: define MC_CONTROLLER_BNE_EN to decode bne (op 000101)
// into BNEEX; without it bne goes to ERROR like any unknown opcode.
module mc_controller
    import mc_pkg::*;
#(
    parameter int ALUC_W  = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              pcen,
    output logic              memwrite,
    output logic              irwrite,
    output logic              regwrite,
    output logic              alusrca,
    output logic              iord,
    output logic              memtoreg,
    output logic              regdst,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              error,
    output logic [3:0]        state_o,
    output logic [CNT_W-1:0]  instret
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instret_q;
    logic              funct_ok;
    logic              waiting;
    logic              retire;
    mc_ctrl_t          ctrl;

    mc_aludec #(
        .ALUC_W(ALUC_W)
    ) u_aludec (
        .aluop     (ctrl.aluop),
        .funct     (funct),
        .alucontrol(alucontrol),
        .funct_ok  (funct_ok)
    );

    // A cycle counts as waiting only in a handshake state with mem_ready low.
    assign waiting = is_wait_state(state) && !mem_ready;

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = funct_ok ? RTYPEEX : ERROR;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       next_state = BNEEX;
`endif
                    default:      next_state = ERROR;
                endcase
            end
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) next_state = MEMWB;
            MEMWR:   if (mem_ready) next_state = FETCH;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = ADDIWB;
            MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX: next_state = FETCH;
`ifdef MC_CONTROLLER_BNE_EN
            BNEEX:   next_state = FETCH;
`endif
            ERROR:   next_state = ERROR;
            default: next_state = ERROR;
        endcase
        // The TIMEOUT-th waiting edge lands in ERROR instead of bumping the counter.
        if (waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1))) begin
            next_state = ERROR;
        end
    end

    assign retire = is_terminal(state) && (next_state == FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            instret_q <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    // Output decode. pcen/irwrite in FETCH follow mem_ready combinationally so
    // the PC and IR load on the same edge the fetch completes; they are also
    // held low while reset is asserted.
    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALUOP_ADD;
        case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.pcen    = mem_ready & reset;
                ctrl.irwrite = mem_ready & reset;
            end
            DECODE: begin
                ctrl.alusrcb = 2'b11;
            end
            MEMADR, ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.pcsrc   = 2'b01;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcen    = zero;
            end
`ifdef MC_CONTROLLER_BNE_EN
            BNEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.pcsrc   = 2'b01;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcen    = ~zero;
            end
`endif
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcen  = 1'b1;
                ctrl.pcsrc = 2'b10;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign mem_req  = ctrl.mem_req;
    assign pcen     = ctrl.pcen;
    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign error    = (state == ERROR);
    assign state_o  = state;
    assign instret  = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller -- self-checking bench for mc_controller.
//
// The reference model describes each instruction as the list of states it
// walks through, expands handshake states with waiting cycles and derives
// every output from a per-state table. Expected outputs are pushed once per
// cycle and compared on the falling edge.
module tb_mc_controller;

    localparam int ALUC_W  = 6;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;
    localparam int EXP_W   = 28;

    logic              clk;
    logic              reset;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic              zero;
    logic              mem_ready;
    logic              mem_req;
    logic              pcen;
    logic              memwrite;
    logic              irwrite;
    logic              regwrite;
    logic              alusrca;
    logic              iord;
    logic              memtoreg;
    logic              regdst;
    logic [1:0]        alusrcb;
    logic [1:0]        pcsrc;
    logic [ALUC_W-1:0] alucontrol;
    logic              error;
    logic [3:0]        state_o;
    logic [CNT_W-1:0]  instret;

    mc_controller #(
        .ALUC_W (ALUC_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .pcen      (pcen),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .alucontrol(alucontrol),
        .error     (error),
        .state_o   (state_o),
        .instret   (instret)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int                checks = 0;
    int                errors = 0;
    logic [EXP_W-1:0]  exp_q[$];

    // model state
    int                plan[$];
    int                wcnt = 0;
    int                m_instret = 0;
    logic [5:0]        cur_op = 6'b000010;
    logic [5:0]        cur_funct = 6'b000000;
    logic [11:0]       instr_q[$];

    // samples taken at the falling edge for directed checks
    logic [3:0]        s_state;
    logic [3:0]        s_instret;
    logic              s_pcen, s_irwrite, s_memreq, s_memwrite, s_error;
    logic [ALUC_W-1:0] s_aluc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal_funct(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                         6'b100111, 6'b100110, 6'b101010};
    endfunction

    // State sequence an instruction walks through (12 = halted).
    function automatic void build_plan(input logic [5:0] o, input logic [5:0] f);
        plan.delete();
        plan.push_back(0);
        plan.push_back(1);
        case (o)
            6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
            6'b101011: begin plan.push_back(2); plan.push_back(5); end
            6'b000000: begin
                if (legal_funct(f)) begin plan.push_back(6); plan.push_back(7); end
                else plan.push_back(12);
            end
            6'b000100: plan.push_back(8);
            6'b001000: begin plan.push_back(9); plan.push_back(10); end
            6'b000010: plan.push_back(11);
`ifdef MC_CONTROLLER_BNE_EN
            6'b000101: plan.push_back(13);
`endif
            default:   plan.push_back(12);
        endcase
    endfunction

    function automatic logic [11:0] rand_instr();
        int r;
        logic [5:0] fl[7];
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b101010};
        r = $urandom_range(0, 99);
        if (r < 20)      return {6'b100011, 6'($urandom)};
        else if (r < 35) return {6'b101011, 6'($urandom)};
        else if (r < 55) return {6'b000000, fl[$urandom_range(0, 6)]};
        else if (r < 58) return {6'b000000, 6'b000001};
        else if (r < 70) return {6'b000100, 6'($urandom)};
        else if (r < 80) return {6'b001000, 6'($urandom)};
        else if (r < 90) return {6'b000010, 6'($urandom)};
        else if (r < 95) return {6'b000101, 6'($urandom)};
        else             return {6'b001100, 6'd0};
    endfunction

    function automatic void start_instr();
        if (instr_q.size() > 0) {cur_op, cur_funct} = instr_q.pop_front();
        else                    {cur_op, cur_funct} = rand_instr();
        build_plan(cur_op, cur_funct);
    endfunction

    // Outputs expected in the current cycle: {state, instret, controls}.
    function automatic logic [EXP_W-1:0] model_out(input bit rst, input bit mr, input bit z);
        int st;
        logic mreq, pce, mw, irw, rw, asa, iod, m2r, rdst, err;
        logic [1:0] asb, psrc;
        logic [5:0] aluc;
        logic [3:0] ir;
        {mreq, pce, mw, irw, rw, asa, iod, m2r, rdst, err} = '0;
        asb = 2'd0; psrc = 2'd0; aluc = 6'd0;
        st = rst ? plan[0] : 0;
        ir = rst ? m_instret[3:0] : 4'd0;
        case (st)
            0:  begin mreq = 1; asb = 2'b01; pce = mr & rst; irw = mr & rst; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mreq = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; iod = 1; mw = 1; end
            6:  begin asa = 1; aluc = {2'b00, cur_funct[3:0]}; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; psrc = 2'b01; aluc = 6'b000010; pce = z; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pce = 1; psrc = 2'b10; end
            12: err = 1;
            13: begin asa = 1; psrc = 2'b01; aluc = 6'b000010; pce = ~z; end
            default: err = 0;
        endcase
        return {st[3:0], ir, mreq, pce, mw, irw, rw, asa, iod, m2r, rdst, asb, psrc, aluc, err};
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_step(input bit rst, input bit mr);
        int st;
        if (!rst) begin
            m_instret = 0;
            wcnt = 0;
            build_plan(cur_op, cur_funct);
            return;
        end
        st = plan[0];
        if (st == 12) return;
        if ((st == 0 || st == 3 || st == 5) && !mr) begin
            wcnt++;
            if (wcnt == TIMEOUT) begin
                plan.delete();
                plan.push_back(12);
                wcnt = 0;
            end
            return;
        end
        wcnt = 0;
        void'(plan.pop_front());
        if (plan.size() == 0) begin
            m_instret = (m_instret + 1) % (1 << CNT_W);
            start_instr();
        end
    endfunction

    // ---------------- compare process ----------------
    function automatic logic [19:0] dut_ctl();
        return {mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
                regdst, alusrcb, pcsrc, alucontrol, error};
    endfunction

    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("state_o", 32'(state_o), 32'(e[27:24]));
                check("instret", 32'(instret), 32'(e[23:20]));
                check("controls", 32'(dut_ctl()), 32'(e[19:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input bit rst, input bit mr, input bit z);
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        op        = cur_op;
        funct     = cur_funct;
        exp_q.push_back(model_out(rst, mr, z));
        @(negedge clk);
        s_state    = state_o;
        s_instret  = instret;
        s_pcen     = pcen;
        s_irwrite  = irwrite;
        s_memreq   = mem_req;
        s_memwrite = memwrite;
        s_error    = error;
        s_aluc     = alucontrol;
        model_step(rst, mr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        start_instr();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_seq[6];
        int fc, pc, ic;
        bit seen;
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 6'd0; funct = 6'd0;
        exp_seq = '{0, 1, 2, 3, 4, 0};
        @(posedge clk);
        #1;

        // lw with mem_ready held high; reset values checked with mem_ready=1
        instr_q.push_back({6'b100011, 6'd0});
        do_reset();
        check("reset_state", 32'(s_state), 0);
        check("reset_instret", 32'(s_instret), 0);
        check("reset_error", 32'(s_error), 0);
        check("reset_pcen", 32'(s_pcen), 0);
        check("reset_irwrite", 32'(s_irwrite), 0);
        check("reset_memreq", 32'(s_memreq), 1);
        for (int k = 0; k < 6; k++) begin
            cycle(1, 1, 0);
            check("lw_state", 32'(s_state), 32'(exp_seq[k]));
            if (k == 0 || k == 3) check("lw_memreq", 32'(s_memreq), 1);
        end
        check("lw_instret", 32'(s_instret), 1);

        // fetch stalled three cycles
        instr_q.push_back({6'b000010, 6'd0});
        do_reset();
        fc = 0; pc = 0; ic = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1, k >= 3, 0);
            if (s_state == 4'd0) fc++;
            pc += int'(s_pcen);
            ic += int'(s_irwrite);
        end
        check("stall_fetch_cycles", 32'(fc), 4);
        check("stall_pcen_pulses", 32'(pc), 1);
        check("stall_irwrite_pulses", 32'(ic), 1);

        // fetch timeout
        instr_q.push_back({6'b000010, 6'd0});
        do_reset();
        fc = 0; seen = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 0, 0);
            if (s_state == 4'd12) seen = 1;
            else if (!seen && s_state == 4'd0) fc++;
        end
        check("timeout_fetch_cycles", 32'(fc), 15);
        check("timeout_error", 32'(s_error), 1);
        check("timeout_memreq", 32'(s_memreq), 0);
        for (int k = 0; k < 3; k++) cycle(1, 1, 1);
        check("error_held_state", 32'(s_state), 12);
        check("error_held_pcen", 32'(s_pcen), 0);

        // beq taken then not taken
        instr_q.push_back({6'b000100, 6'd0});
        instr_q.push_back({6'b000100, 6'd0});
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(1, 1, k < 3);
            if (k == 2) begin
                check("beq1_state", 32'(s_state), 8);
                check("beq1_pcen", 32'(s_pcen), 1);
            end
            if (k == 5) begin
                check("beq2_state", 32'(s_state), 8);
                check("beq2_pcen", 32'(s_pcen), 0);
            end
        end
        check("beq_instret", 32'(s_instret), 2);

        // illegal R-type funct
        instr_q.push_back({6'b000000, 6'b000000});
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 1, 0);
        check("rtype_bad_state", 32'(s_state), 12);
        check("rtype_bad_error", 32'(s_error), 1);

        // slt ALU code
        instr_q.push_back({6'b000000, 6'b101010});
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 1, 0);
        check("slt_state", 32'(s_state), 6);
        check("slt_alucontrol", 32'(s_aluc), 32'h0a);

        // bne
        instr_q.push_back({6'b000101, 6'd0});
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 1, 0);
`ifdef MC_CONTROLLER_BNE_EN
        check("bne_state", 32'(s_state), 13);
        check("bne_pcen", 32'(s_pcen), 1);
`else
        check("bne_state", 32'(s_state), 12);
`endif

        // 16 jumps wrap the 4-bit counter
        for (int k = 0; k < 16; k++) instr_q.push_back({6'b000010, 6'd0});
        do_reset();
        for (int k = 0; k < 49; k++) begin
            cycle(1, 1, 0);
            if (k == 45) check("wrap_instret_15", 32'(s_instret), 15);
            if (k == 48) check("wrap_instret_0", 32'(s_instret), 0);
        end

        // reset during a stalled store
        instr_q.push_back({6'b101011, 6'd0});
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 1, 0);
        cycle(1, 0, 0);
        check("memwr_state", 32'(s_state), 5);
        check("memwr_memwrite", 32'(s_memwrite), 1);
        reset = 1'b0;
        #1;
        check("async_reset_state", 32'(state_o), 0);
        check("async_reset_memwrite", 32'(memwrite), 0);
        do_reset();

        // random instruction stream
        for (int i = 0; i < 3000; i++) begin
            if (plan[0] == 12 && $urandom_range(0, 3) == 0) do_reset();
            else if ($urandom_range(0, 299) == 0) do_reset();
            else cycle(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter ALUC_W, default 4, ALU control width; upper bits above bit 3 driven 0.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles per memory access.
REQ-003 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- op  in  6  opcode.
- funct  in  6  R-type function.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete.
- mem_req  out  1  memory access request.
- pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst  out  1 each  datapath controls.
- alusrcb, pcsrc  out  2 each  mux selects.
- alucontrol  out  ALUC_W  ALU operation.
- error  out  1  controller halted.
- state_o  out  4  current state.
- instret  out  CNT_W  retired instructions.

Function
REQ-006 SHALL implement these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, ERROR (0-12), plus BNEEX (13) when enabled.
REQ-007 SHALL make DECODE transitions: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> RTYPEEX if funct is legal, else ERROR; beq (000100) -> BEQEX; addi (001000) -> ADDIEX; j (000010) -> JEX; any other op -> ERROR.
REQ-008 SHALL make the remaining transitions:
- MEMADR: -> MEMRD (lw) or MEMWR (sw).
- MEMRD -> MEMWB.
- RTYPEEX -> RTYPEWB.
- ADDIEX -> ADDIWB.
- MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
REQ-009 SHALL, in FETCH, MEMRD and MEMWR, assert mem_req and hold state until mem_ready=1; the state advances on the edge where mem_ready=1.
REQ-010 SHALL assert pcen and irwrite in FETCH only in cycles with mem_ready=1; memwrite is asserted throughout MEMWR.
REQ-011 SHALL use a wait counter that counts waiting cycles, clears on every state change, and forces ERROR on the edge where it reaches TIMEOUT while mem_ready=0.
REQ-012 SHALL drive these per-state controls (unlisted controls = 0):
- FETCH: alusrcb=01, aluop add.
- DECODE: alusrcb=11, aluop add.
- MEMADR/ADDIEX: alusrca=1, alusrcb=10, aluop add.
- MEMRD/MEMWR: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- RTYPEEX: alusrca=1, aluop funct.
- RTYPEWB: regwrite=1, regdst=1.
- BEQEX: alusrca=1, pcsrc=01, aluop sub, pcen=zero.
- ADDIWB: regwrite=1.
- JEX: pcen=1, pcsrc=10.
REQ-013 SHALL decode the ALU: add->0000; sub->0010; funct 100000/100010/100100/100101/100111/100110/101010 -> 0000/0010/0100/0101/0111/0110/1010.
REQ-014 SHALL, in ERROR: error=1, all write enables 0, mem_req=0, and the state is held until reset.
REQ-015 SHALL increment instret by 1 on each transition from a terminal state to FETCH, wrapping from all-ones to 0; ERROR never increments it.
REQ-016 SHALL drive state_o with the current state encoding.

Reset
REQ-017 SHALL, while reset=0: state=FETCH, wait counter=0, instret=0, error=0; outputs take the FETCH values with pcen=irwrite=0.
REQ-018 SHALL, when reset is asserted mid-access (mem_req=1), return to FETCH asynchronously and discard the access.

Configuration
REQ-019 SHALL gate BNE support on macro MC_CONTROLLER_BNE_EN.
- Defined: op 000101 -> BNEEX; BNEEX drives BEQEX controls with pcen=~zero, then -> FETCH and counts as retired.
- Undefined: op 000101 -> ERROR.

Structure
REQ-020 SHALL place in shared package mc_pkg: state encodings, opcode and funct constants, aluop codes (00 add, 01 sub, 10 funct).
REQ-021 SHALL implement ALU decode as sub-module mc_aludec (combinational, outputs alucontrol and a legal-funct flag); the FSM, wait counter and instret stay in mc_controller.

Verification
REQ-022 SHALL verify: reset released, mem_ready held 1, op=100011 -> states 0,1,2,3,4,0; mem_req high in FETCH and MEMRD; instret=1.
REQ-023 SHALL verify: FETCH with mem_ready low for 3 cycles then high -> state_o=0 for 4 cycles; pcen/irwrite pulse for 1 cycle only.
REQ-024 SHALL verify: TIMEOUT=15, mem_ready never asserted in FETCH -> ERROR on cycle 15; error=1; outputs idle until reset.
REQ-025 SHALL verify: op=000100 with zero=1, then zero=0 -> pcen=1 in the first BEQEX, 0 in the second; instret=2.
REQ-026 SHALL verify: op=000000, funct=000000 -> ERROR from DECODE; op=000101 -> BNEEX with macro, ERROR without.
REQ-027 SHALL verify: CNT_W=4, 16 j instructions -> instret wraps to 0; reset asserted during MEMWR -> FETCH, memwrite=0 immediately.
